// File: rtl/shift_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : shift_operand_stage
// Brief    : Shift-instruction decode, operand/amount select with forwarding,
//            and a two-entry (output register + skid) valid/ready stage.
// Revision : 1.0
// ============================================================================
module shift_operand_stage #(
    parameter logic [3:0] SHIFT_IMM_OP = 4'b1010,
    parameter logic [3:0] SHIFT_REG_OP = 4'b1011,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      instr,
    input  logic [15:0]      rs_data,
    input  logic [15:0]      rt_data,
    input  logic             fwd_valid,
    input  logic [2:0]       fwd_addr,
    input  logic [15:0]      fwd_data,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [15:0]      sh_datain,
    output logic [3:0]       sh_amt,
    output logic [1:0]       sh_code,
    output logic [2:0]       sh_rd,
    output logic             illegal,
    output logic [CNT_W-1:0] shift_count
);

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  amt;
        logic [1:0]  code;
        logic [2:0]  rd;
    } entry_t;

    localparam entry_t     c_ENTRY_ZERO = '{data: 16'h0000, amt: 4'h0, code: 2'b00, rd: 3'b000};
    localparam [CNT_W-1:0] c_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam [CNT_W-1:0] c_CNT_MAX    = {CNT_W{1'b1}};

    // Only the low nibble of rt is a meaningful shift amount.
    logic w_unused_rt_hi;
    assign w_unused_rt_hi = ^rt_data[15:4];

    logic [3:0]  w_opcode;
    logic [2:0]  w_rs;
    logic [2:0]  w_rt;
    logic        w_is_imm;
    logic        w_is_shift;
    logic [15:0] w_operand;
    logic [3:0]  w_amt;
    entry_t      w_entry;
    logic        w_accept;
    logic        w_load;
    logic        w_xfer;

    entry_t          or_entry_q, or_entry_d;
    entry_t          sk_entry_q, sk_entry_d;
    logic            or_valid_q, or_valid_d;
    logic            sk_valid_q, sk_valid_d;
    logic            in_ready_q, in_ready_d;
    logic            illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign w_opcode   = instr[15:12];
    assign w_rs       = instr[8:6];
    assign w_rt       = instr[2:0];
    assign w_is_imm   = (w_opcode == SHIFT_IMM_OP);
    assign w_is_shift = w_is_imm || (w_opcode == SHIFT_REG_OP);

    always_comb begin
        w_operand = 16'h0000;
        w_amt     = 4'h0;
        if (w_rs != 3'd0) begin
            w_operand = (fwd_valid && (fwd_addr == w_rs)) ? fwd_data : rs_data;
        end
        if (w_is_imm) begin
            w_amt = instr[3:0];
        end else if (w_rt != 3'd0) begin
            w_amt = (fwd_valid && (fwd_addr == w_rt)) ? fwd_data[3:0] : rt_data[3:0];
        end
        w_entry = '{data: w_operand, amt: w_amt, code: instr[5:4], rd: instr[11:9]};
    end

    assign w_accept = in_valid && in_ready_q && !flush;
    assign w_load   = w_accept && w_is_shift;
    assign w_xfer   = or_valid_q && out_ready;

    always_comb begin
        or_entry_d = or_entry_q;
        sk_entry_d = sk_entry_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        illegal_d  = 1'b0;
        count_d    = count_q;

        // A transfer coincident with flush is still a completed handshake.
        if (w_xfer && (count_q != c_CNT_MAX)) begin
            count_d = count_q + c_CNT_ONE;
        end

        if (flush) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else begin
            illegal_d = w_accept && !w_is_shift;
            if (!or_valid_q || w_xfer) begin
                if (sk_valid_q) begin
                    or_entry_d = sk_entry_q;
                    or_valid_d = 1'b1;
                    sk_valid_d = w_load;
                    if (w_load) begin
                        sk_entry_d = w_entry;
                    end
                end else if (w_load) begin
                    or_entry_d = w_entry;
                    or_valid_d = 1'b1;
                end else begin
                    or_valid_d = 1'b0;
                end
            end else if (w_load) begin
                sk_entry_d = w_entry;
                sk_valid_d = 1'b1;
            end
        end

        in_ready_d = !sk_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_entry_q <= c_ENTRY_ZERO;
            sk_entry_q <= c_ENTRY_ZERO;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
            in_ready_q <= 1'b1;
            illegal_q  <= 1'b0;
            count_q    <= '0;
        end else begin
            or_entry_q <= or_entry_d;
            sk_entry_q <= sk_entry_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
            in_ready_q <= in_ready_d;
            illegal_q  <= illegal_d;
            count_q    <= count_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = or_valid_q;
    assign sh_datain   = or_entry_q.data;
    assign sh_amt      = or_entry_q.amt;
    assign sh_code     = or_entry_q.code;
    assign sh_rd       = or_entry_q.rd;
    assign illegal     = illegal_q;
    assign shift_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_operand_stage
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0
// ============================================================================
module tb_shift_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic        fwd_valid;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] sh_datain;
    logic [3:0]  sh_amt;
    logic [1:0]  sh_code;
    logic [2:0]  sh_rd;
    logic        illegal;
    logic [15:0] shift_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  amt;
        logic [1:0]  code;
        logic [2:0]  rd;
    } item_t;

    shift_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .sh_datain(sh_datain), .sh_amt(sh_amt), .sh_code(sh_code), .sh_rd(sh_rd),
        .illegal(illegal), .shift_count(shift_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] rsd,
                         input logic [15:0] rtd, input logic fv, input logic [2:0] fa,
                         input logic [15:0] fd, input logic ordy, input logic fl);
        in_valid = v; instr = ins; rs_data = rsd; rt_data = rtd;
        fwd_valid = fv; fwd_addr = fa; fwd_data = fd; out_ready = ordy; flush = fl;
    endtask

    // Reference decode straight from the instruction-field rules.
    function automatic item_t ref_decode(input logic [15:0] ins, input logic [15:0] rsd,
                                         input logic [15:0] rtd, input logic fv,
                                         input logic [2:0] fa, input logic [15:0] fd);
        item_t it;
        int rs = ins[8:6];
        int rt = ins[2:0];
        it.code = ins[5:4];
        it.rd   = ins[11:9];
        if (rs == 0)                 it.data = 16'h0000;
        else if (fv && fa == rs)     it.data = fd;
        else                         it.data = rsd;
        if (ins[15:12] == 4'hA)      it.amt = ins[3:0];
        else if (rt == 0)            it.amt = 4'h0;
        else if (fv && fa == rt)     it.amt = fd[3:0];
        else                         it.amt = rtd[3:0];
        return it;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 16'hA3D4, 16'hCCCC, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid act=%0h exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready act=%0h exp=1", in_ready); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal act=%0h exp=0", illegal); end
        checks++; if (shift_count !== 16'h0) begin errors++; $display("FAIL rst_count act=%0h exp=0", shift_count); end
        checks++; if ({sh_datain, sh_amt, sh_code, sh_rd} !== 25'h0) begin errors++;
            $display("FAIL rst_outputs act=%0h/%0h/%0h/%0h exp=0", sh_datain, sh_amt, sh_code, sh_rd); end
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_imm();
        drive(1'b1, 16'hA3D4, 16'hCCCC, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL imm_valid act=%0h exp=1", out_valid); end
        checks++; if ({sh_datain, sh_amt, sh_code, sh_rd} !== {16'hCCCC, 4'd4, 2'b01, 3'd1}) begin errors++;
            $display("FAIL imm_fields act=%0h/%0h/%0h/%0h exp=cccc/4/1/1", sh_datain, sh_amt, sh_code, sh_rd); end
        tick();
        checks++; if (shift_count !== 16'd1) begin errors++; $display("FAIL imm_count act=%0h exp=1", shift_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL imm_drain act=%0h exp=0", out_valid); end
    endtask

    task automatic test_reg_fwd();
        drive(1'b1, 16'hB1AB, 16'h00F0, 16'h0005, 1'b1, 3'd3, 16'h0009, 1'b1, 1'b0);
        tick();
        checks++; if ({sh_datain, sh_amt, sh_code, sh_rd} !== {16'h00F0, 4'd9, 2'b10, 3'd0}) begin errors++;
            $display("FAIL reg_fwd_rt act=%0h/%0h/%0h/%0h exp=00f0/9/2/0", sh_datain, sh_amt, sh_code, sh_rd); end
        drive(1'b1, 16'hB1AB, 16'h00F0, 16'h0005, 1'b1, 3'd6, 16'h0009, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        checks++; if ({sh_datain, sh_amt} !== {16'h0009, 4'd5}) begin errors++;
            $display("FAIL reg_fwd_rs act=%0h/%0h exp=0009/5", sh_datain, sh_amt); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 16'hA072, 16'h1111, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 act=%0h exp=1", in_ready); end
        drive(1'b1, 16'hA493, 16'h2222, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready act=%0h exp=0", in_ready); end
        tick();
        checks++; if ({out_valid, sh_datain, sh_amt, sh_code, sh_rd} !== {1'b1, 16'h1111, 4'd2, 2'b11, 3'd0}) begin errors++;
            $display("FAIL b2b_hold act=%0h/%0h/%0h/%0h/%0h exp=1/1111/2/3/0", out_valid, sh_datain, sh_amt, sh_code, sh_rd); end
        out_ready = 1'b1;
        tick();
        checks++; if ({out_valid, sh_datain, sh_amt, sh_code, sh_rd} !== {1'b1, 16'h2222, 4'd3, 2'b01, 3'd2}) begin errors++;
            $display("FAIL b2b_second act=%0h/%0h/%0h/%0h/%0h exp=1/2222/3/1/2", out_valid, sh_datain, sh_amt, sh_code, sh_rd); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back act=%0h exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty act=%0h exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 16'h1234, 16'hAAAA, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        checks++; if ({out_valid, illegal} !== 2'b01) begin errors++;
            $display("FAIL illegal_pulse act=%0h/%0h exp=0/1", out_valid, illegal); end
        tick();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_clear act=%0h exp=0", illegal); end
        checks++; if (shift_count !== 16'd5) begin errors++; $display("FAIL illegal_count act=%0h exp=5", shift_count); end
    endtask

    task automatic test_flush();
        drive(1'b1, 16'hA072, 16'h1111, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'hA493, 16'h2222, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'hA3D4, 16'h3333, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        tick();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++;
            $display("FAIL flush_full act=%0h/%0h exp=0/1", out_valid, in_ready); end
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop act=%0h exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after act=%0h exp=0", out_valid); end
    endtask

    task automatic test_random();
        item_t q[$];
        item_t it;
        logic  exp_ready, exp_ill, acc, xfer;
        int    exp_cnt;
        rst = 1'b1;
        drive(1'b1, 16'hA3D4, 16'h5555, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        exp_ready = 1'b1; exp_ill = 1'b0; exp_cnt = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int sel = $urandom_range(0, 9);
            logic [15:0] ins = 16'($urandom);
            if (sel < 4)      ins[15:12] = 4'hA;
            else if (sel < 8) ins[15:12] = 4'hB;
            drive(($urandom_range(0, 3) != 0), ins, 16'($urandom), 16'($urandom),
                  1'($urandom), 3'($urandom), 16'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
            checks++; if (out_valid !== (q.size() > 0)) begin errors++;
                $display("FAIL rnd_valid cyc=%0d act=%0h exp=%0h", cyc, out_valid, q.size() > 0); end
            checks++; if ({in_ready, illegal} !== {exp_ready, exp_ill}) begin errors++;
                $display("FAIL rnd_ready_ill cyc=%0d act=%0h/%0h exp=%0h/%0h", cyc, in_ready, illegal, exp_ready, exp_ill); end
            checks++; if (shift_count !== 16'(exp_cnt)) begin errors++;
                $display("FAIL rnd_count cyc=%0d act=%0h exp=%0h", cyc, shift_count, exp_cnt); end
            if (q.size() > 0) begin
                checks++; if ({sh_datain, sh_amt, sh_code, sh_rd} !== q[0]) begin errors++;
                    $display("FAIL rnd_data cyc=%0d act=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", cyc, sh_datain,
                             sh_amt, sh_code, sh_rd, q[0].data, q[0].amt, q[0].code, q[0].rd); end
            end
            acc  = in_valid && exp_ready && !flush;
            xfer = (q.size() > 0) && out_ready;
            it   = ref_decode(instr, rs_data, rt_data, fwd_valid, fwd_addr, fwd_data);
            tick();
            if (xfer) begin
                void'(q.pop_front());
                if (exp_cnt < 65535) exp_cnt++;
            end
            if (flush) begin
                q.delete();
                exp_ill = 1'b0;
            end else begin
                exp_ill = acc && !(instr[15:12] inside {4'hA, 4'hB});
                if (acc && !exp_ill) q.push_back(it);
            end
            exp_ready = (q.size() < 2);
        end
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        tick(); tick(); tick();
    endtask

    task automatic test_saturate_rs0();
        int n = 0;
        drive(1'b1, 16'hA3D4, 16'hCCCC, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        while (shift_count !== 16'hFFFF && n < 66000) begin
            tick();
            n++;
        end
        checks++; if (shift_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach act=%0h exp=ffff", shift_count); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_stream act=%0h exp=1", out_valid); end
        tick();
        checks++; if (shift_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold act=%0h exp=ffff", shift_count); end
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'hA621, 16'hBEEF, 16'h0, 1'b1, 3'd0, 16'h1234, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        checks++; if ({out_valid, sh_datain, sh_amt, sh_code, sh_rd} !== {1'b1, 16'h0000, 4'd1, 2'b10, 3'd3}) begin errors++;
            $display("FAIL rs0_operand act=%0h/%0h/%0h/%0h/%0h exp=1/0000/1/2/3", out_valid, sh_datain, sh_amt, sh_code, sh_rd); end
        tick();
        checks++; if (shift_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final act=%0h exp=ffff", shift_count); end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        test_reset();
        test_imm();
        test_reg_fwd();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_random();
        test_saturate_rs0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
